// File: rtl/pulse_period_detector.sv
`default_nettype none
// ============================================================================
// Module   : pulse_period_detector
// Brief    : Measures high width and preceding low gap of optical pulses,
//            window-checks both, reports accept/reject strobes, lock and LOS.
//            Optional glitch filter: define PULSE_DET_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_period_detector #(
    parameter logic [31:0] WIDTH_MIN = 32'd900000,
    parameter logic [31:0] WIDTH_MAX = 32'd1100000,
    parameter logic [31:0] GAP_MIN   = 32'd2700000,
    parameter logic [31:0] GAP_MAX   = 32'd3300000,
    parameter logic [31:0] TIMEOUT   = 32'd8000000,
    parameter logic [7:0]  LOCK_CNT  = 8'd4
`ifdef PULSE_DET_GLITCH_FILTER_EN
    ,
    parameter int          GLITCH_LEN = 4
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pulse,
    output logic        o_valid,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_width,
    output logic [31:0] o_gap,
    output logic        o_lock,
    output logic        o_lost
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_GAP  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t      state_q;
    logic        s1_q, s2_q, s3_q;
    logic        w_lvl;
    logic [31:0] gap_cnt_q, width_cnt_q, gap_q;
    logic [7:0]  lock_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= i_pulse;
            s2_q <= s1_q;
        end
    end

`ifdef PULSE_DET_GLITCH_FILTER_EN
    localparam int GW = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;
    localparam logic [GW-1:0] GL_LAST = GW'(GLITCH_LEN - 1);

    logic          filt_q;
    logic [GW-1:0] stab_q;

    // Filtered level follows s2 only after GLITCH_LEN consecutive disagreeing samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else if (s2_q == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == GL_LAST) begin
            filt_q <= s2_q;
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + GW'(1);
        end
    end

    assign w_lvl = filt_q;
`else
    assign w_lvl = s2_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= w_lvl;
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        w_rise, w_fall;
    logic [31:0] w_gap_inc, w_width_inc;
    logic        w_gap_to, w_width_to;
    logic        w_width_ok, w_gap_ok;
    logic [7:0]  w_lock_inc;

    assign w_rise      = w_lvl & ~s3_q;
    assign w_fall      = ~w_lvl & s3_q;
    assign w_gap_inc   = sat_inc(gap_cnt_q);
    assign w_width_inc = sat_inc(width_cnt_q);
    assign w_gap_to    = ~w_lvl & (w_gap_inc >= TIMEOUT);
    assign w_width_to  = w_lvl & (w_width_inc >= TIMEOUT);
    assign w_width_ok  = (width_cnt_q >= WIDTH_MIN) && (width_cnt_q <= WIDTH_MAX);
    assign w_gap_ok    = (gap_q >= GAP_MIN) && (gap_q <= GAP_MAX);
    assign w_lock_inc  = (lock_cnt_q >= LOCK_CNT) ? LOCK_CNT : lock_cnt_q + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_INIT;
            gap_cnt_q   <= 32'd0;
            width_cnt_q <= 32'd0;
            gap_q       <= 32'd0;
            lock_cnt_q  <= 8'd0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 2'b00;
            o_width     <= 32'd0;
            o_gap       <= 32'd0;
            o_lock      <= 1'b0;
            o_lost      <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state_q)
                S_INIT: begin
                    // Only a falling edge gives a fully measurable next gap
                    if (w_fall) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= 32'd1;
                        o_lost    <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (w_gap_to) begin
                        state_q    <= S_INIT;
                        gap_cnt_q  <= 32'd0;
                        lock_cnt_q <= 8'd0;
                        o_lock     <= 1'b0;
                        o_lost     <= 1'b1;
                    end else if (w_rise) begin
                        state_q     <= S_HIGH;
                        gap_q       <= gap_cnt_q;
                        width_cnt_q <= 32'd1;
                    end else begin
                        gap_cnt_q <= w_gap_inc;
                    end
                end
                S_HIGH: begin
                    if (w_width_to) begin
                        state_q     <= S_INIT;
                        width_cnt_q <= 32'd0;
                        lock_cnt_q  <= 8'd0;
                        o_lock      <= 1'b0;
                        o_lost      <= 1'b1;
                    end else if (w_fall) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= 32'd1;
                        o_width   <= width_cnt_q;
                        o_gap     <= gap_q;
                        if (w_width_ok && w_gap_ok) begin
                            o_valid    <= 1'b1;
                            lock_cnt_q <= w_lock_inc;
                            o_lock     <= (w_lock_inc == LOCK_CNT);
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= {~w_gap_ok, ~w_width_ok};
                            lock_cnt_q <= 8'd0;
                            o_lock     <= 1'b0;
                        end
                    end else begin
                        width_cnt_q <= w_width_inc;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    o_lost  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_period_detector
// Brief    : Directed self-checking bench for pulse_period_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_period_detector;

`ifdef PULSE_DET_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pulse = 1'b0;
    logic        o_valid, o_err, o_lock, o_lost;
    logic [1:0]  o_err_code;
    logic [31:0] o_width, o_gap;

    int n_tests = 0;
    int n_fail  = 0;
    int ecyc    = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;
    int stb_cyc = 0;

    pulse_period_detector #(
        .WIDTH_MIN (32'd8),
        .WIDTH_MAX (32'd12),
        .GAP_MIN   (32'd16),
        .GAP_MAX   (32'd24),
        .TIMEOUT   (32'd64),
        .LOCK_CNT  (8'd3)
`ifdef PULSE_DET_GLITCH_FILTER_EN
        ,
        .GLITCH_LEN(2)
`endif
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_pulse   (i_pulse),
        .o_valid   (o_valid),
        .o_err     (o_err),
        .o_err_code(o_err_code),
        .o_width   (o_width),
        .o_gap     (o_gap),
        .o_lock    (o_lock),
        .o_lost    (o_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecyc <= ecyc + 1;

    always @(negedge clk) begin
        if (o_valid && o_err) n_both = n_both + 1;
        if (o_valid) n_valid = n_valid + 1;
        if (o_err) n_err = n_err + 1;
        if (o_valid || o_err) stb_cyc = ecyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at 1ns after a rising edge; input is sampled at the next n edges
    task automatic hold(input logic lvl, input int n);
        i_pulse = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_chk(input string name, input int hi, input int lo, input bit exp_ok,
                             input int w, input int g, input logic [1:0] code, input logic lock);
        int nv0, ne0, fe;
        nv0 = n_valid;
        ne0 = n_err;
        hold(1'b1, hi);
        fe = ecyc;
        hold(1'b0, lo);
        check({name, ".valid"}, 32'(n_valid - nv0), exp_ok ? 32'd1 : 32'd0);
        check({name, ".err"},   32'(n_err - ne0),   exp_ok ? 32'd0 : 32'd1);
        check({name, ".lat"},   32'(stb_cyc - fe),  32'(LAT));
        check({name, ".width"}, o_width, 32'(w));
        check({name, ".gap"},   o_gap,   32'(g));
        if (!exp_ok) check({name, ".code"}, {30'd0, o_err_code}, {30'd0, code});
        check({name, ".lock"},  {31'd0, o_lock}, {31'd0, lock});
    endtask

    task automatic no_strobe(input string name, input int nv0, input int ne0);
        check({name, ".nv"}, 32'(n_valid - nv0), 32'd0);
        check({name, ".ne"}, 32'(n_err - ne0),   32'd0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, ".valid"}, {31'd0, o_valid}, 32'd0);
        check({name, ".err"},   {31'd0, o_err},   32'd0);
        check({name, ".code"},  {30'd0, o_err_code}, 32'd0);
        check({name, ".width"}, o_width, 32'd0);
        check({name, ".gap"},   o_gap,   32'd0);
        check({name, ".lock"},  {31'd0, o_lock},  32'd0);
        check({name, ".lost"},  {31'd0, o_lost},  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nv0, ne0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        i_rst = 1'b0;
        hold(1'b0, 5);

        // Leading pulse only leaves S_INIT
        nv0 = n_valid; ne0 = n_err;
        hold(1'b1, 10);
        hold(1'b0, 20);
        no_strobe("init", nv0, ne0);
        check("init.lost", {31'd0, o_lost}, 32'd0);

        pulse_chk("p1", 10, 20, 1'b1, 10, 20, 2'b00, 1'b0);
        pulse_chk("p2", 10, 20, 1'b1, 10, 20, 2'b00, 1'b0);
        pulse_chk("p3", 10, 20, 1'b1, 10, 20, 2'b00, 1'b1);
        pulse_chk("wide", 14, 16, 1'b0, 14, 20, 2'b01, 1'b0);
        pulse_chk("min",   8, 24, 1'b1,  8, 16, 2'b00, 1'b0);
        pulse_chk("max",  12, 25, 1'b1, 12, 24, 2'b00, 1'b0);
        pulse_chk("both",  7, 30, 1'b0,  7, 25, 2'b11, 1'b0);
        pulse_chk("gapb", 10, 20, 1'b0, 10, 30, 2'b10, 1'b0);
        pulse_chk("l1",   10, 20, 1'b1, 10, 20, 2'b00, 1'b0);
        pulse_chk("l2",   10, 20, 1'b1, 10, 20, 2'b00, 1'b0);
        pulse_chk("l3",   10, 20, 1'b1, 10, 20, 2'b00, 1'b1);

        // Loss of signal after a long low run
        hold(1'b1, 10);
        hold(1'b0, 64);
        nv0 = n_valid; ne0 = n_err;
        check("to.strobe_w", o_width, 32'd10);
        hold(1'b0, LAT - 2);
        check("to.lost_pre", {31'd0, o_lost}, 32'd0);
        hold(1'b0, 1);
        check("to.lost", {31'd0, o_lost}, 32'd1);
        check("to.lock", {31'd0, o_lock}, 32'd0);
        hold(1'b1, 10);
        hold(1'b0, 20);
        no_strobe("to", nv0, ne0);
        check("to.relost", {31'd0, o_lost}, 32'd0);
        pulse_chk("rec1", 10, 20, 1'b1, 10, 20, 2'b00, 1'b0);
        pulse_chk("rec2", 10, 20, 1'b1, 10, 20, 2'b00, 1'b0);
        pulse_chk("rec3", 10, 20, 1'b1, 10, 20, 2'b00, 1'b1);

        // Reset in the middle of a high pulse
        hold(1'b1, 5);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        i_rst = 1'b0;
        nv0 = n_valid; ne0 = n_err;
        hold(1'b1, 5);
        hold(1'b0, 20);
        no_strobe("midrst", nv0, ne0);
        check("midrst.lost", {31'd0, o_lost}, 32'd0);
        pulse_chk("post", 10, 20, 1'b1, 10, 20, 2'b00, 1'b0);

`ifdef PULSE_DET_GLITCH_FILTER_EN
        hold(1'b1, 10);
        hold(1'b0, 8);
        hold(1'b1, 1);
        hold(1'b0, 11);
        pulse_chk("glitch", 10, 20, 1'b1, 10, 20, 2'b00, 1'b1);
`endif

        check("exclusive", 32'(n_both), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
